// File: rtl/calendar_display_scan_if.sv
// Date inputs and scanned 7-segment outputs of calendar_display_scan.
// The slave modport is the display block; the master drives the date.
interface calendar_display_scan_if;
    logic [6:0] year;
    logic [4:0] month;
    logic [4:0] day;
    logic [6:0] seg;
    logic [5:0] an;
    logic       dp;
    logic       bcd_valid;

    modport master (output year, month, day, input seg, an, dp, bcd_valid);
    modport slave  (input year, month, day, output seg, an, dp, bcd_valid);
endinterface

// File: rtl/calendar_display_scan.sv
// Snapshots year/month/day, converts them to BCD with one shared double-dabble engine and
// scans six 7-segment digits as DD.MM.YY. Define CAL_DISP_BLANK_EN to blank zero day/month tens.
module calendar_display_scan #(
    parameter logic [15:0] REFRESH_DIV    = 16'd50000,
    parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    calendar_display_scan_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StConv, StDone} state_e;

    state_e           state_q, state_d;
    logic [6:0]       snap_year_q;
    logic [4:0]       snap_month_q, snap_day_q;
    logic             primed_q;
    logic [1:0]       field_q;
    logic [2:0]       bit_q;
    logic [6:0]       bin_q;
    logic [11:0]      bcd_q;
    logic [7:0]       res_year_q, res_month_q;
    logic [5:0][3:0]  dig_q;
    logic             year_dash_q;
    logic             bcd_valid_q;
    logic [15:0]      cnt_q;
    logic [2:0]       idx_q;
    logic [6:0]       seg_q;
    logic [5:0]       an_q;
    logic             dp_q;

    logic        changed, capture, shift_en, commit, blank;
    logic [11:0] bcd_adj, bcd_next;
    logic [6:0]  bin_next, seg_hi;
    logic [5:0]  an_hi;
    logic        dp_hi;
    logic [3:0]  digit;

    assign changed = !primed_q ||
                     ({bus.year, bus.month, bus.day} != {snap_year_q, snap_month_q, snap_day_q});

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= StIdle;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (changed) state_d = StConv;
            StConv:  if (field_q == 2'd2 && bit_q == 3'd6) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        capture  = 1'b0;
        shift_en = 1'b0;
        commit   = 1'b0;
        unique case (state_q)
            StIdle:  capture  = changed;
            StConv:  shift_en = 1'b1;
            StDone:  commit   = 1'b1;
            default: ;
        endcase
    end

    // Add-3 correction precedes each shift so no nibble overflows past 9.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 3; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
        bcd_next = {bcd_adj[10:0], bin_q[6]};
        bin_next = {bin_q[5:0], 1'b0};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            snap_year_q  <= '0;
            snap_month_q <= '0;
            snap_day_q   <= '0;
            primed_q     <= 1'b0;
            field_q      <= '0;
            bit_q        <= '0;
            bin_q        <= '0;
            bcd_q        <= '0;
            res_year_q   <= '0;
            res_month_q  <= '0;
            dig_q        <= '0;
            year_dash_q  <= 1'b0;
            bcd_valid_q  <= 1'b0;
        end else begin
            bcd_valid_q <= commit;
            if (capture) begin
                snap_year_q  <= bus.year;
                snap_month_q <= bus.month;
                snap_day_q   <= bus.day;
                bin_q        <= bus.year;
                bcd_q        <= '0;
                field_q      <= '0;
                bit_q        <= '0;
            end else if (shift_en) begin
                if (bit_q == 3'd6 && field_q != 2'd2) begin
                    bcd_q   <= '0;
                    bit_q   <= '0;
                    field_q <= field_q + 2'd1;
                    if (field_q == 2'd0) begin
                        res_year_q <= bcd_next[7:0];
                        bin_q      <= {2'b00, snap_month_q};
                    end else begin
                        res_month_q <= bcd_next[7:0];
                        bin_q       <= {2'b00, snap_day_q};
                    end
                end else begin
                    // Day result stays in bcd_q until the commit cycle.
                    bcd_q <= bcd_next;
                    bin_q <= bin_next;
                    bit_q <= bit_q + 3'd1;
                end
            end
            if (commit) begin
                dig_q       <= {bcd_q[7:0], res_month_q, res_year_q};
                year_dash_q <= (snap_year_q > 7'd99);
                primed_q    <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else if (cnt_q == REFRESH_DIV - 16'd1) begin
            cnt_q <= '0;
            idx_q <= (idx_q == 3'd0) ? 3'd5 : idx_q - 3'd1;
        end else begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    always_comb begin
        unique case (idx_q)
            3'd5:    digit = dig_q[5];
            3'd4:    digit = dig_q[4];
            3'd3:    digit = dig_q[3];
            3'd2:    digit = dig_q[2];
            3'd1:    digit = dig_q[1];
            default: digit = dig_q[0];
        endcase
    end

`ifdef CAL_DISP_BLANK_EN
    assign blank = (idx_q == 3'd5 || idx_q == 3'd3) && (digit == 4'd0);
`else
    assign blank = 1'b0;
`endif

    always_comb begin
        unique case (digit)
            4'd0:    seg_hi = 7'h3F;
            4'd1:    seg_hi = 7'h06;
            4'd2:    seg_hi = 7'h5B;
            4'd3:    seg_hi = 7'h4F;
            4'd4:    seg_hi = 7'h66;
            4'd5:    seg_hi = 7'h6D;
            4'd6:    seg_hi = 7'h7D;
            4'd7:    seg_hi = 7'h07;
            4'd8:    seg_hi = 7'h7F;
            4'd9:    seg_hi = 7'h6F;
            default: seg_hi = 7'h00;
        endcase
        if (idx_q < 3'd2 && year_dash_q) seg_hi = 7'h40;
        if (blank) seg_hi = 7'h00;
        an_hi = 6'd1 << idx_q;
        dp_hi = (idx_q == 3'd4) || (idx_q == 3'd2);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seg_q <= {7{SEG_ACTIVE_LOW}};
            an_q  <= {6{SEG_ACTIVE_LOW}};
            dp_q  <= SEG_ACTIVE_LOW;
        end else begin
            seg_q <= SEG_ACTIVE_LOW ? ~seg_hi : seg_hi;
            an_q  <= SEG_ACTIVE_LOW ? ~an_hi : an_hi;
            dp_q  <= SEG_ACTIVE_LOW ? ~dp_hi : dp_hi;
        end
    end

    assign bus.seg       = seg_q;
    assign bus.an        = an_q;
    assign bus.dp        = dp_q;
    assign bus.bcd_valid = bcd_valid_q;
endmodule
